// File: rtl/sha256_pad_if.sv
// Byte-in / word-out handshake bundle for the SHA-256 padding front end.
interface sha256_pad_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_word;
    logic        out_first;
    logic        out_last;
    logic        out_final;
    logic        out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_word, out_first, out_last, out_final
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_word, out_first, out_last, out_final
    );
endinterface

// File: rtl/sha256_pad.sv
// SHA-256 message padder: buffers bytes into 64-byte blocks, appends the
// 0x80 marker and 64-bit length, and streams 16 big-endian words per block.
module sha256_pad (
    input  logic        clk,
    input  logic        rst,
    sha256_pad_if.slave bus
);
    typedef enum logic [1:0] {ABSORB, PAD, EMIT, PAD2} state_t;
    typedef enum logic [1:0] {NONE, LEN, MARK} pend_t;

    state_t      state_q, state_d;
    pend_t       pend_q;
    logic [7:0]  blk [64];
    logic [7:0]  lenb [8];
    logic [6:0]  datalen_q;
    logic [63:0] bitlen_q;
    logic [3:0]  widx_q;
    logic        final_q;
    logic        take, give;

    assign take = bus.in_valid && bus.in_ready;
    assign give = bus.out_valid && bus.out_ready;

    assign bus.in_ready  = !rst && (state_q == ABSORB);
    assign bus.out_valid = !rst && (state_q == EMIT);
    assign bus.out_first = bus.out_valid && (widx_q == 4'd0);
    assign bus.out_last  = bus.out_valid && (widx_q == 4'd15);
    assign bus.out_final = bus.out_valid && final_q;
    assign bus.out_word  = bus.out_valid ?
        {blk[{widx_q, 2'd0}], blk[{widx_q, 2'd1}],
         blk[{widx_q, 2'd2}], blk[{widx_q, 2'd3}]} : 32'd0;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            lenb[k] = bitlen_q[63 - 8 * k -: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ABSORB: begin
                if (take && bus.in_last) state_d = PAD;
                else if (take && datalen_q == 7'd63) state_d = EMIT;
            end
            PAD:  state_d = EMIT;
            EMIT: begin
                if (give && widx_q == 4'd15)
                    state_d = (pend_q == NONE) ? ABSORB : PAD2;
            end
            PAD2: state_d = EMIT;
            default: state_d = ABSORB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ABSORB;
            datalen_q <= '0;
            bitlen_q  <= '0;
            widx_q    <= '0;
            final_q   <= 1'b0;
            pend_q    <= NONE;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ABSORB: begin
                    if (take) begin
                        datalen_q <= datalen_q + 7'd1;
                        bitlen_q  <= bitlen_q + 64'd8;
                    end
                end
                PAD: begin
                    if (datalen_q[6]) pend_q <= MARK;
                    else if (datalen_q <= 7'd55) begin
                        final_q <= 1'b1;
                        pend_q  <= NONE;
                    end else pend_q <= LEN;
                end
                EMIT: begin
                    if (give) begin
                        widx_q <= widx_q + 4'd1;
                        if (widx_q == 4'd15 && pend_q == NONE) begin
                            datalen_q <= '0;
                            if (final_q) begin
                                bitlen_q <= '0;
                                final_q  <= 1'b0;
                            end
                        end
                    end
                end
                PAD2: begin
                    final_q <= 1'b1;
                    pend_q  <= NONE;
                end
                default: ;
            endcase
        end
    end

    // Data buffer needs no reset: every block is fully rewritten before use.
    always_ff @(posedge clk) begin
        unique case (state_q)
            ABSORB: begin
                if (take) blk[datalen_q[5:0]] <= bus.in_data;
            end
            PAD: begin
                if (!datalen_q[6]) begin
                    for (int i = 0; i < 64; i++) begin
                        if (7'(i) == datalen_q)
                            blk[i] <= 8'h80;
                        else if (7'(i) > datalen_q)
                            blk[i] <= (i >= 56 && datalen_q <= 7'd55) ?
                                      lenb[3'(i)] : 8'h00;
                    end
                end
            end
            PAD2: begin
                for (int i = 0; i < 64; i++) begin
                    if (i >= 56) blk[i] <= lenb[3'(i)];
                    else if (i == 0 && pend_q == MARK) blk[i] <= 8'h80;
                    else blk[i] <= 8'h00;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sha256_pad.sv
// Bench for sha256_pad: FIPS 180-4 padding model, per-cycle word
// scoreboard, stall-hold checks and directed timing/reset scenarios.
module tb_sha256_pad;
    typedef logic [7:0] bq_t [$];
    typedef struct packed {
        logic [31:0] w;
        logic        f;
        logic        l;
        logic        fin;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    sha256_pad_if bus ();

    sha256_pad dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_fail = 0;
    int   n_pop = 0;
    exp_t expq [$];
    int   bp_mode = 0;
    logic man_ready = 1'b0;
    int   ph = 0;
    logic stalled = 1'b0;
    exp_t prev;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference padding: message, 0x80, zeros to 56 mod 64, length.
    task automatic build(input bq_t m);
        bq_t         b;
        logic [63:0] len;
        int          nblk;
        exp_t        e;
        b = m;
        len = 64'(m.size()) * 64'd8;
        b.push_back(8'h80);
        while (b.size() % 64 != 56) b.push_back(8'h00);
        for (int k = 0; k < 8; k++) b.push_back(len[63 - 8 * k -: 8]);
        nblk = b.size() / 64;
        for (int bi = 0; bi < nblk; bi++) begin
            for (int w = 0; w < 16; w++) begin
                int o;
                o = bi * 64 + w * 4;
                e.w   = {b[o], b[o + 1], b[o + 2], b[o + 3]};
                e.f   = (w == 0);
                e.l   = (w == 15);
                e.fin = (bi == nblk - 1);
                expq.push_back(e);
            end
        end
    endtask

    always @(posedge clk) begin
        #3;
        case (bp_mode)
            0: bus.out_ready = 1'b1;
            1: begin
                bus.out_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
            default: bus.out_ready = man_ready;
        endcase
    end

    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        if (rst) stalled = 1'b0;
        else if (bus.out_valid) begin
            cur = {bus.out_word, bus.out_first, bus.out_last, bus.out_final};
            chk("in_ready_during_emit", 64'(bus.in_ready), 64'd0);
            if (stalled) chk("hold_while_stalled", 64'(cur), 64'(prev));
            if (bus.out_ready) begin
                if (expq.size() == 0)
                    chk("spurious_word", 64'(expq.size()), 64'd1);
                else begin
                    e = expq.pop_front();
                    chk("out_word", 64'(cur.w), 64'(e.w));
                    chk("out_first", 64'(cur.f), 64'(e.f));
                    chk("out_last", 64'(cur.l), 64'(e.l));
                    chk("out_final", 64'(cur.fin), 64'(e.fin));
                    n_pop++;
                end
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev = cur;
            end
        end else stalled = 1'b0;
    end

    task automatic send_byte(input logic [7:0] b, input logic l);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = l;
        while (!bus.in_ready && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        if (t >= 500) chk("in_ready_timeout", 64'(t), 64'd0);
        @(negedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("drain_left", 64'(expq.size()), 64'd0);
        @(negedge clk); #1;
        chk("in_ready_after_block", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic run_msg(input bq_t m);
        for (int i = 0; i < m.size(); i++)
            send_byte(m[i], i == m.size() - 1);
        drain();
    endtask

    function automatic bq_t fill(input int n, input bit inc);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(inc ? 8'(i) : 8'h00);
        return q;
    endfunction

    initial begin
        bq_t abc;
        bq_t m;
        int  n;
        int  t;
        abc = '{8'h61, 8'h62, 8'h63};
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_first", 64'(bus.out_first), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_out_final", 64'(bus.out_final), 64'd0);
        chk("rst_out_word", 64'(bus.out_word), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk); #1;
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        // "abc" with latency and emit-rate checks
        build(abc);
        chk("model_abc_w0", 64'(expq[0].w), 64'h61626380);
        chk("model_abc_w15", 64'(expq[15].w), 64'h18);
        chk("model_abc_final", 64'(expq[15].fin), 64'd1);
        for (int i = 0; i < 3; i++) send_byte(abc[i], i == 2);
        chk("abc_valid_T1", 64'(bus.out_valid), 64'd0);
        @(negedge clk); #1;
        chk("abc_valid_T2", 64'(bus.out_valid), 64'd1);
        n = 0;
        while (bus.out_valid && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("abc_block_cycles", 64'(n), 64'd16);
        chk("abc_in_ready_back", 64'(bus.in_ready), 64'd1);
        chk("abc_drained", 64'(expq.size()), 64'd0);

        m = fill(55, 1'b0);
        build(m);
        chk("model_55_w13", 64'(expq[13].w), 64'h80);
        chk("model_55_w15", 64'(expq[15].w), 64'h1b8);
        run_msg(m);

        m = fill(56, 1'b0);
        build(m);
        chk("model_56_blocks", 64'(expq.size()), 64'd32);
        chk("model_56_b1w14", 64'(expq[14].w), 64'h80000000);
        chk("model_56_b1fin", 64'(expq[15].fin), 64'd0);
        chk("model_56_b2w15", 64'(expq[31].w), 64'h1c0);
        run_msg(m);

        m = fill(64, 1'b0);
        build(m);
        chk("model_64_b2w0", 64'(expq[16].w), 64'h80000000);
        chk("model_64_b2w15", 64'(expq[31].w), 64'h200);
        run_msg(m);

        // 70 bytes: a full mid-message block, then a short final one
        m = fill(70, 1'b1);
        build(m);
        chk("model_70_b2w15", 64'(expq[31].w), 64'h230);
        for (int i = 0; i < 64; i++) send_byte(m[i], 1'b0);
        chk("full_block_valid_T1", 64'(bus.out_valid), 64'd1);
        for (int i = 64; i < 70; i++) send_byte(m[i], i == 69);
        drain();

        bp_mode = 1;
        build(abc);
        run_msg(abc);
        bp_mode = 0;

        // Reset while word 7 is on the bus
        man_ready = 1'b0;
        bp_mode = 2;
        build(abc);
        for (int i = 0; i < 3; i++) send_byte(abc[i], i == 2);
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        chk("rstmid_valid_seen", 64'(bus.out_valid), 64'd1);
        n = n_pop;
        man_ready = 1'b1;
        repeat (7) @(negedge clk);
        #1;
        man_ready = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        chk("rstmid_words_before", 64'(n_pop - n), 64'd7);
        @(negedge clk); #1;
        chk("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rstmid_in_ready", 64'(bus.in_ready), 64'd0);
        expq.delete();
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk); #1;
        chk("rstmid_in_ready_after", 64'(bus.in_ready), 64'd1);
        chk("rstmid_no_resume", 64'(bus.out_valid), 64'd0);
        bp_mode = 0;
        build(abc);
        run_msg(abc);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sha256_pad.md
# sha256_pad

SHA-256 message front end. Accepts a byte stream, applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length), and delivers 512-bit blocks to the compression core as 16 big-endian 32-bit words over a valid/ready handshake. Sits between the byte source and the `sha256` core, producing the message schedule input W[0..15] block by block. Holds the 64-byte block buffer, the fill count and the 64-bit bit length for the message in flight.

## Interface
- No parameters. Block size is fixed at 64 bytes, word width at 32 bits and length field at 64 bits.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte available.
- in_data  in  8  message byte.
- in_last  in  1  qualifies the final byte of the message. Messages are at least 1 byte long.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_valid  out  1  word available.
- out_word  out  32  block word, big-endian: {b[4i], b[4i+1], b[4i+2], b[4i+3]}.
- out_first  out  1  word index 0 of the block.
- out_last  out  1  word index 15 of the block.
- out_final  out  1  the block is the last one of the message; held on all 16 words.
- out_ready  in  1  word consumed when out_valid && out_ready.

## Operation
- **State ABSORB**
  - in_ready=1. Each accepted byte is stored at buf[datalen]; datalen increments; bitlen += 8, modulo 2^64.
  - If the byte is not last and datalen reaches 64, go to EMIT with pend=NONE.
  - If in_last is accepted, go to PAD.
- **State PAD** (one cycle, in_ready=0)
  - If datalen<64: set buf[datalen]=0x80 and zero buf[datalen+1..63].
    - If datalen<=55: write bitlen big-endian into buf[56..63], set final=1, pend=NONE.
    - Otherwise (56..63): final=0, pend=LEN.
  - If datalen==64: the buffer is left as is, final=0, pend=MARK.
  - Go to EMIT.
- **State EMIT** (in_ready=0)
  - out_valid=1. Word index widx runs 0..15 and advances only on a handshake.
  - out_word, out_first, out_last and out_final are stable while the handshake is stalled.
  - After the handshake at widx=15:
    - pend=NONE and final=1: clear datalen, bitlen and final; go to ABSORB.
    - pend=NONE and final=0 (full mid-message block): clear datalen; go to ABSORB.
    - pend=LEN or pend=MARK: go to PAD2.
- **State PAD2** (one cycle)
  - Zero the whole buffer.
  - If pend=MARK, set buf[0]=0x80.
  - Write bitlen into buf[56..63]; set final=1, pend=NONE; go to EMIT.
- bitlen counts message bits only. Padding never increments it.
- rst at any time, including mid-block or mid-pad, returns the block to ABSORB with datalen=0, bitlen=0, widx=0, final=0, pend=NONE. A partially emitted block is dropped; no further words are emitted for it.

## Timing
- **Reset values:** out_valid=0, out_first=0, out_last=0, out_final=0, out_word=0. in_ready=0 while rst is high and 1 in the cycle after rst is released.
- **Last byte:** accepted in cycle T → PAD in T+1 → out_valid=1 with word 0 in T+2.
- **Full block (64th byte, not last):** accepted in T → out_valid in T+1.
- **Emit rate:** with out_ready held at 1, one block takes exactly 16 cycles.
- **Turnaround into a second pad block:** the last word of the first block handshakes in T → PAD2 in T+1 → word 0 of the second block in T+2.
- **Back to input:** after a final or mid-message block completes in T, in_ready=1 in T+1.
- **No overlap:** input is never accepted while EMIT, PAD or PAD2 is active.

## Test plan
- **"abc"** (0x61, 0x62, 0x63 with last on 0x63) → one block with out_final=1. w0=0x61626380, w1..w14=0, w15=0x00000018. out_valid rises 2 cycles after the last byte.
- **55 bytes of 0x00** → one final block. w13=0x00000080, w14=0, w15=0x000001B8.
- **56 bytes of 0x00** → two blocks.
  - Block 1: w14=0x80000000, w15=0, out_final=0.
  - Block 2: w0..w14=0, w15=0x000001C0, out_final=1.
- **64 bytes of 0x00**, last on byte 64 → block 1 all zero with out_final=0. Block 2: w0=0x80000000, w15=0x00000200, out_final=1.
- **Backpressure:** "abc" with out_ready toggling 1,0,0,1,… → the same 16 words in order. Outputs hold while stalled, out_first/out_last align with words 0 and 15, and in_ready stays 0 until the final handshake.
- **Reset mid-emit:** rst pulsed while widx=7 → out_valid=0 the next cycle. A following "abc" yields exactly the "abc" block, showing no stale bitlen or buffer contents.
